bin_sched_ctrl: RTL and testbench



---
 rtl/sat_bin_pkg.sv | 25 ++
 rtl/onehot_dec.sv | 17 +
 rtl/bin_sched_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_bin_sched_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sat_bin_pkg.sv
// Shared definitions for the bin scheduling controller: FSM state
// encoding and default sizing constants for a bin.
package sat_bin_pkg;

  localparam int DEF_NUM_CLAUSES      = 8;
  localparam int DEF_NUM_VARS         = 8;
  localparam int DEF_NUM_LVLS         = 8;
  localparam int DEF_WIDTH_BIN_ID     = 10;
  localparam int DEF_WIDTH_LVL        = 16;
  localparam int DEF_WIDTH_VAR_STATES = 19;
  localparam int DEF_WIDTH_LVL_STATES = 11;

  // Sequencer states, in the order a bin walks through them
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LD_C  = 3'd1,
    ST_LD_S  = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4,
    ST_UP_C  = 3'd5,
    ST_UP_S  = 3'd6,
    ST_DONE  = 3'd7
  } bsc_state_t;

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot row decoder. With en low every output bit is 0, so a
// single instance can serve both the clause load and clause read-back
// row selects without ever asserting more than one row.
module onehot_dec #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         en,
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign onehot[gi] = en && (idx == W'(gi));
  end

endmodule

// File: rtl/bin_sched_ctrl.sv
// Bin sequencer around the SAT engine: loads a bin's clauses and states
// from bin memory into the engine, starts it, waits for completion, then
// writes the clauses and states back and reports the verdict.
module bin_sched_ctrl
  import sat_bin_pkg::*;
#(
  parameter int NUM_CLAUSES      = DEF_NUM_CLAUSES,
  parameter int NUM_VARS         = DEF_NUM_VARS,
  parameter int NUM_LVLS         = DEF_NUM_LVLS,
  parameter int WIDTH_BIN_ID     = DEF_WIDTH_BIN_ID,
  parameter int WIDTH_LVL        = DEF_WIDTH_LVL,
  parameter int WIDTH_VAR_STATES = DEF_WIDTH_VAR_STATES,
  parameter int WIDTH_LVL_STATES = DEF_WIDTH_LVL_STATES,
  parameter int WIDTH_CIDX       = $clog2(NUM_CLAUSES)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [WIDTH_BIN_ID-1:0]              bin_id_i,
  input  logic [WIDTH_LVL-1:0]                 load_lvl_i,
  input  logic [WIDTH_LVL-1:0]                 base_lvl_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 sat_o,
  output logic                                 unsat_o,
  output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
  output logic [WIDTH_BIN_ID-1:0]              mem_bin_o,
  output logic                                 cmem_rd_o,
  output logic                                 cmem_wr_o,
  output logic [WIDTH_CIDX-1:0]                cmem_idx_o,
  output logic [2*NUM_VARS-1:0]                cmem_wdata_o,
  input  logic [2*NUM_VARS-1:0]                cmem_rdata_i,
  output logic                                 smem_rd_o,
  output logic                                 smem_wr_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] smem_vs_wdata_o,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] smem_vs_rdata_i,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] smem_ls_wdata_o,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] smem_ls_rdata_i,
  output logic                                 eng_start_o,
  input  logic                                 eng_done_i,
  input  logic                                 eng_sat_i,
  input  logic                                 eng_unsat_i,
  input  logic [WIDTH_LVL-1:0]                 eng_bkt_lvl_i,
  output logic [WIDTH_LVL-1:0]                 eng_load_lvl_o,
  output logic [NUM_CLAUSES-1:0]               eng_rd_carray_o,
  input  logic [2*NUM_VARS-1:0]                eng_clause_i,
  output logic [NUM_CLAUSES-1:0]               eng_wr_carray_o,
  output logic [2*NUM_VARS-1:0]                eng_clause_o,
  output logic [NUM_VARS-1:0]                  eng_wr_vs_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] eng_vs_o,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] eng_vs_i,
  output logic [NUM_LVLS-1:0]                  eng_wr_ls_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] eng_ls_o,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] eng_ls_i,
  output logic                                 eng_base_lvl_en_o,
  output logic [WIDTH_LVL-1:0]                 eng_base_lvl_o
);

  // k must reach NUM_CLAUSES in LD_C (one extra cycle for the read latency)
  localparam int KW = $clog2(NUM_CLAUSES + 1);

  bsc_state_t              state_reg, state_next;
  logic [KW-1:0]           k_reg, k_next;
  logic [WIDTH_BIN_ID-1:0] bin_reg;
  logic [WIDTH_LVL-1:0]    load_lvl_reg;
  logic [WIDTH_LVL-1:0]    base_lvl_reg;
  logic [WIDTH_LVL-1:0]    bkt_lvl_reg;
  logic                    sat_reg;
  logic                    unsat_reg;

  logic                    accept;
  logic                    latch_verdict;
  logic                    ld_c_wr;
  logic                    ld_s_wr;
  logic                    up_c_rd;
  logic                    sel_en;
  logic [WIDTH_CIDX-1:0]   sel_idx;
  logic [NUM_CLAUSES-1:0]  sel_onehot;

  // Shared row decoder: LD_C drives it with k-1 (data arrives one cycle
  // after the read), UP_C with k; the two states are mutually exclusive.
  onehot_dec #(
    .N (NUM_CLAUSES),
    .W (WIDTH_CIDX)
  ) u_row_dec (
    .en     (sel_en),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  // Next-state, counter and strobe generation
  always_comb begin
    state_next        = state_reg;
    k_next            = k_reg;
    accept            = 1'b0;
    latch_verdict     = 1'b0;
    ld_c_wr           = 1'b0;
    ld_s_wr           = 1'b0;
    up_c_rd           = 1'b0;
    sel_en            = 1'b0;
    sel_idx           = '0;
    done_o            = 1'b0;
    cmem_rd_o         = 1'b0;
    cmem_wr_o         = 1'b0;
    cmem_idx_o        = '0;
    smem_rd_o         = 1'b0;
    smem_wr_o         = 1'b0;
    eng_start_o       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          accept     = 1'b1;
          k_next     = '0;
          state_next = ST_LD_C;
        end
      end
      ST_LD_C: begin
        if (k_reg < KW'(NUM_CLAUSES)) begin
          cmem_rd_o  = 1'b1;
          cmem_idx_o = WIDTH_CIDX'(k_reg);
        end
        if (k_reg != '0) begin
          ld_c_wr = 1'b1;
          sel_en  = 1'b1;
          sel_idx = WIDTH_CIDX'(k_reg - 1'b1);
        end
        if (k_reg == KW'(NUM_CLAUSES)) begin
          k_next     = '0;
          state_next = ST_LD_S;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      ST_LD_S: begin
        if (k_reg == '0) begin
          smem_rd_o = 1'b1;
          k_next    = KW'(1);
        end else begin
          ld_s_wr    = 1'b1;
          k_next     = '0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        eng_start_o = 1'b1;
        state_next  = ST_RUN;
      end
      ST_RUN: begin
        // done is only honoured here, so a stray early pulse is dropped
        if (eng_done_i) begin
          latch_verdict = 1'b1;
          k_next        = '0;
          state_next    = ST_UP_C;
        end
      end
      ST_UP_C: begin
        up_c_rd    = 1'b1;
        sel_en     = 1'b1;
        sel_idx    = WIDTH_CIDX'(k_reg);
        cmem_wr_o  = 1'b1;
        cmem_idx_o = WIDTH_CIDX'(k_reg);
        if (k_reg == KW'(NUM_CLAUSES - 1)) begin
          k_next     = '0;
          state_next = ST_UP_S;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      ST_UP_S: begin
        smem_wr_o  = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done_o     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        k_next     = '0;
      end
    endcase
  end

  // Data paths are kept out of the FSM block so the engine's combinational
  // clause read-back never feeds the logic that selects the row.
  assign eng_wr_carray_o   = ld_c_wr ? sel_onehot : '0;
  assign eng_rd_carray_o   = up_c_rd ? sel_onehot : '0;
  assign eng_clause_o      = ld_c_wr ? cmem_rdata_i : '0;
  assign cmem_wdata_o      = up_c_rd ? eng_clause_i : '0;
  assign eng_wr_vs_o       = ld_s_wr ? '1 : '0;
  assign eng_wr_ls_o       = ld_s_wr ? '1 : '0;
  assign eng_vs_o          = ld_s_wr ? smem_vs_rdata_i : '0;
  assign eng_ls_o          = ld_s_wr ? smem_ls_rdata_i : '0;
  assign eng_base_lvl_en_o = ld_s_wr;
  assign eng_base_lvl_o    = ld_s_wr ? base_lvl_reg : '0;
  assign smem_vs_wdata_o   = smem_wr_o ? eng_vs_i : '0;
  assign smem_ls_wdata_o   = smem_wr_o ? eng_ls_i : '0;

  assign busy_o         = (state_reg != ST_IDLE);
  assign eng_load_lvl_o = busy_o ? load_lvl_reg : '0;
  assign mem_bin_o      = bin_reg;
  assign sat_o          = sat_reg;
  assign unsat_o        = unsat_reg;
  assign bkt_lvl_o      = bkt_lvl_reg;

  // State, counter, captured request and latched verdict registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      k_reg        <= '0;
      bin_reg      <= '0;
      load_lvl_reg <= '0;
      base_lvl_reg <= '0;
      sat_reg      <= 1'b0;
      unsat_reg    <= 1'b0;
      bkt_lvl_reg  <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      if (accept) begin
        bin_reg      <= bin_id_i;
        load_lvl_reg <= load_lvl_i;
        base_lvl_reg <= base_lvl_i;
        sat_reg      <= 1'b0;
        unsat_reg    <= 1'b0;
        bkt_lvl_reg  <= '0;
      end
      if (latch_verdict) begin
        sat_reg     <= eng_sat_i;
        unsat_reg   <= eng_unsat_i;
        bkt_lvl_reg <= eng_bkt_lvl_i;
      end
    end
  end

endmodule

// File: tb/tb_bin_sched_ctrl.sv
// Directed bench for bin_sched_ctrl: bin memory and SAT engine are small
// behavioural models; every output is compared cycle by cycle against
// hand-derived timing for NUM_CLAUSES = 8.
module tb_bin_sched_ctrl;

  localparam int NC  = 8;
  localparam int NV  = 8;
  localparam int NL  = 8;
  localparam int WB  = 10;
  localparam int WL  = 16;
  localparam int WVS = 19;
  localparam int WLS = 11;
  localparam int WC  = 3;
  localparam int CW  = 2 * NV;

  localparam logic [WVS*NV-1:0] SMEM_VS = {NV{19'h12345}};
  localparam logic [WLS*NL-1:0] SMEM_LS = {NL{11'h155}};
  localparam logic [WVS*NV-1:0] ENG_VS  = {NV{19'h2A5C3}};
  localparam logic [WLS*NL-1:0] ENG_LS  = {NL{11'h3C5}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, start_i;
  logic [WB-1:0]       bin_id_i;
  logic [WL-1:0]       load_lvl_i, base_lvl_i;
  logic                busy_o, done_o, sat_o, unsat_o;
  logic [WL-1:0]       bkt_lvl_o;
  logic [WB-1:0]       mem_bin_o;
  logic                cmem_rd_o, cmem_wr_o;
  logic [WC-1:0]       cmem_idx_o;
  logic [CW-1:0]       cmem_wdata_o, cmem_rdata_i;
  logic                smem_rd_o, smem_wr_o;
  logic [WVS*NV-1:0]   smem_vs_wdata_o, smem_vs_rdata_i;
  logic [WLS*NL-1:0]   smem_ls_wdata_o, smem_ls_rdata_i;
  logic                eng_start_o, eng_done_i, eng_sat_i, eng_unsat_i;
  logic [WL-1:0]       eng_bkt_lvl_i, eng_load_lvl_o;
  logic [NC-1:0]       eng_rd_carray_o, eng_wr_carray_o;
  logic [CW-1:0]       eng_clause_i, eng_clause_o;
  logic [NV-1:0]       eng_wr_vs_o;
  logic [WVS*NV-1:0]   eng_vs_o, eng_vs_i;
  logic [NL-1:0]       eng_wr_ls_o;
  logic [WLS*NL-1:0]   eng_ls_o, eng_ls_i;
  logic                eng_base_lvl_en_o;
  logic [WL-1:0]       eng_base_lvl_o;

  bin_sched_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .bin_id_i(bin_id_i),
    .load_lvl_i(load_lvl_i), .base_lvl_i(base_lvl_i),
    .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o),
    .bkt_lvl_o(bkt_lvl_o), .mem_bin_o(mem_bin_o),
    .cmem_rd_o(cmem_rd_o), .cmem_wr_o(cmem_wr_o), .cmem_idx_o(cmem_idx_o),
    .cmem_wdata_o(cmem_wdata_o), .cmem_rdata_i(cmem_rdata_i),
    .smem_rd_o(smem_rd_o), .smem_wr_o(smem_wr_o),
    .smem_vs_wdata_o(smem_vs_wdata_o), .smem_vs_rdata_i(smem_vs_rdata_i),
    .smem_ls_wdata_o(smem_ls_wdata_o), .smem_ls_rdata_i(smem_ls_rdata_i),
    .eng_start_o(eng_start_o), .eng_done_i(eng_done_i), .eng_sat_i(eng_sat_i),
    .eng_unsat_i(eng_unsat_i), .eng_bkt_lvl_i(eng_bkt_lvl_i),
    .eng_load_lvl_o(eng_load_lvl_o), .eng_rd_carray_o(eng_rd_carray_o),
    .eng_clause_i(eng_clause_i), .eng_wr_carray_o(eng_wr_carray_o),
    .eng_clause_o(eng_clause_o), .eng_wr_vs_o(eng_wr_vs_o), .eng_vs_o(eng_vs_o),
    .eng_vs_i(eng_vs_i), .eng_wr_ls_o(eng_wr_ls_o), .eng_ls_o(eng_ls_o),
    .eng_ls_i(eng_ls_i), .eng_base_lvl_en_o(eng_base_lvl_en_o),
    .eng_base_lvl_o(eng_base_lvl_o)
  );

  // Bin memory model: one-cycle registered read
  logic [CW-1:0] cmem [NC];
  always @(posedge clk) begin
    if (cmem_rd_o) cmem_rdata_i <= cmem[cmem_idx_o];
    if (smem_rd_o) begin
      smem_vs_rdata_i <= SMEM_VS;
      smem_ls_rdata_i <= SMEM_LS;
    end
  end

  // Engine clause array model: row i holds ~i, read combinationally
  always_comb begin
    eng_clause_i = '0;
    for (int i = 0; i < NC; i++)
      if (eng_rd_carray_o[i]) eng_clause_i = ~CW'(i);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bin run. Cycle 0 is the accept cycle (start seen in IDLE); the
  // bench observes cycle c at its falling edge. Expected timing for NC=8:
  // LD_C 1..9, LD_S 10..11, START 12, RUN 13..dc, UP_C dc+1..dc+8,
  // UP_S dc+9, DONE dc+10.
  task automatic run_bin(input logic [WB-1:0] bin, input logic [WL-1:0] ld,
                         input logic [WL-1:0] base, input logic vs, input logic vu,
                         input logic [WL-1:0] bkt, input int dc,
                         input bit early, input bit hold);
    logic [NC-1:0] exp_wc, exp_rc;
    int            exp_idx;
    check("idle_busy", busy_o, 0);
    start_i = 1'b1; bin_id_i = bin; load_lvl_i = ld; base_lvl_i = base;
    for (int c = 1; c <= dc + 10; c++) begin
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      eng_done_i = 1'b0; eng_sat_i = 1'b0; eng_unsat_i = 1'b0; eng_bkt_lvl_i = '0;
      exp_wc = '0;
      exp_rc = '0;
      exp_idx = 0;
      if (c >= 2 && c <= 9) exp_wc[c-2] = 1'b1;
      if (c > dc && c <= dc + 8) exp_rc[c-dc-1] = 1'b1;
      if (c <= 8) exp_idx = c - 1;
      if (c > dc && c <= dc + 8) exp_idx = c - dc - 1;
      check($sformatf("busy c%0d", c), busy_o, 1);
      check($sformatf("done c%0d", c), done_o, c == dc + 10);
      check($sformatf("mem_bin c%0d", c), mem_bin_o, bin);
      check($sformatf("load_lvl c%0d", c), eng_load_lvl_o, ld);
      check($sformatf("cmem_rd c%0d", c), cmem_rd_o, c <= 8);
      check($sformatf("cmem_wr c%0d", c), cmem_wr_o, c > dc && c <= dc + 8);
      check($sformatf("cmem_idx c%0d", c), cmem_idx_o, exp_idx);
      check($sformatf("wr_carray c%0d", c), eng_wr_carray_o, exp_wc);
      check($sformatf("clause_o c%0d", c), eng_clause_o, (c >= 2 && c <= 9) ? (c - 2) * 3 : 0);
      check($sformatf("rd_carray c%0d", c), eng_rd_carray_o, exp_rc);
      check($sformatf("cmem_wdata c%0d", c), cmem_wdata_o,
            (c > dc && c <= dc + 8) ? {240'b0, ~CW'(c - dc - 1)} : 256'b0);
      check($sformatf("smem_rd c%0d", c), smem_rd_o, c == 10);
      check($sformatf("wr_vs c%0d", c), eng_wr_vs_o, (c == 11) ? 8'hFF : 8'h00);
      check($sformatf("wr_ls c%0d", c), eng_wr_ls_o, (c == 11) ? 8'hFF : 8'h00);
      check($sformatf("vs_o c%0d", c), eng_vs_o, (c == 11) ? SMEM_VS : '0);
      check($sformatf("ls_o c%0d", c), eng_ls_o, (c == 11) ? SMEM_LS : '0);
      check($sformatf("base_en c%0d", c), eng_base_lvl_en_o, c == 11);
      check($sformatf("base_lvl c%0d", c), eng_base_lvl_o, (c == 11) ? base : '0);
      check($sformatf("eng_start c%0d", c), eng_start_o, c == 12);
      check($sformatf("smem_wr c%0d", c), smem_wr_o, c == dc + 9);
      check($sformatf("smem_vs_w c%0d", c), smem_vs_wdata_o, (c == dc + 9) ? ENG_VS : '0);
      check($sformatf("smem_ls_w c%0d", c), smem_ls_wdata_o, (c == dc + 9) ? ENG_LS : '0);
      check($sformatf("sat c%0d", c), sat_o, (c > dc) ? vs : 1'b0);
      check($sformatf("unsat c%0d", c), unsat_o, (c > dc) ? vu : 1'b0);
      check($sformatf("bkt c%0d", c), bkt_lvl_o, (c > dc) ? bkt : '0);
      if (early && (c == 10 || c == 12)) begin
        eng_done_i = 1'b1; eng_sat_i = 1'b1; eng_unsat_i = 1'b1; eng_bkt_lvl_i = 16'hDEAD;
      end
      if (c == dc) begin
        eng_done_i = 1'b1; eng_sat_i = vs; eng_unsat_i = vu; eng_bkt_lvl_i = bkt;
      end
    end
    $display("run bin %0d: sat=%0b unsat=%0b bkt_lvl=%0d", bin, sat_o, unsat_o, bkt_lvl_o);
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; bin_id_i = '0; load_lvl_i = '0; base_lvl_i = '0;
    eng_done_i = 1'b0; eng_sat_i = 1'b0; eng_unsat_i = 1'b0; eng_bkt_lvl_i = '0;
    eng_vs_i = ENG_VS; eng_ls_i = ENG_LS;
    for (int i = 0; i < NC; i++) cmem[i] = CW'(i * 3);

    repeat (3) @(negedge clk);
    check("rst busy", busy_o, 0);
    check("rst done", done_o, 0);
    check("rst cmem_rd", cmem_rd_o, 0);
    check("rst eng_start", eng_start_o, 0);
    check("rst mem_bin", mem_bin_o, 0);
    rst = 1'b1;
    @(negedge clk);

    // SAT run: bin 5, done with sat 20 cycles after eng_start (cycle 32)
    run_bin(10'd5, 16'h1234, 16'h0042, 1'b1, 1'b0, 16'd3, 32, 1'b0, 1'b0);
    @(negedge clk);
    check("sat post busy", busy_o, 0);
    check("sat post done", done_o, 0);
    check("sat post hold", sat_o, 1);
    check("sat post load_lvl", eng_load_lvl_o, 0);

    // UNSAT run with early done pulses in LD_S/START and start held high
    run_bin(10'd9, 16'h0077, 16'h0001, 1'b0, 1'b1, 16'd7, 20, 1'b1, 1'b1);
    @(negedge clk);  // cycle 31: IDLE, start still high
    check("unsat idle busy", busy_o, 0);
    check("unsat hold unsat", unsat_o, 1);
    check("unsat hold bkt", bkt_lvl_o, 7);
    check("unsat hold sat", sat_o, 0);
    @(negedge clk);  // cycle 32: accepted on the cycle after DONE
    start_i = 1'b0;
    check("reaccept busy", busy_o, 1);
    check("reaccept cmem_rd", cmem_rd_o, 1);
    check("reaccept unsat clr", unsat_o, 0);
    repeat (3) @(negedge clk);  // LD_C j=3
    check("ldc3 idx", cmem_idx_o, 3);
    check("ldc3 wr_carray", eng_wr_carray_o, 8'h04);
    rst = 1'b0;
    @(negedge clk);
    check("midrst busy", busy_o, 0);
    check("midrst cmem_rd", cmem_rd_o, 0);
    check("midrst wr_carray", eng_wr_carray_o, 0);
    check("midrst idx", cmem_idx_o, 0);
    check("midrst mem_bin", mem_bin_o, 0);
    check("midrst load_lvl", eng_load_lvl_o, 0);
    check("midrst smem_rd", smem_rd_o, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("after rst idle", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
